// File: rtl/eta_corrector_8bit.sv
// rtl/eta_corrector_8bit.sv - serial-low/parallel-high exact-sum corrector for an 8-bit error-tolerant adder
//
// Purpose:
//    Accepts an operand pair (a, b) together with the sum produced by an
//    approximate 8-bit adder. It recomputes the exact sum, one low-nibble bit
//    per cycle and then the whole high nibble in one cycle. It reports the
//    exact sum, the absolute error and an error flag.
//    Optional result statistics are enabled by defining ETA_CORR_STATS_EN.
//
// Ports:
//    clk, rst_n             clock, asynchronous active-low reset
//    in_valid / in_ready    input handshake for the (a, b, approx_sum) triple
//    a, b [7:0]             original adder operands
//    approx_sum [8:0]       approximate adder result
//    out_valid / out_ready  output handshake
//    exact_sum [8:0]        exact a + b
//    err_flag               approx_sum differed from exact_sum
//    err_dist [8:0]         |exact_sum - approx_sum|
//    clr_stats              synchronous clear of the statistics counters
//    op_count, err_count    completed results / erroneous results (saturating)

module eta_corrector_8bit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [8:0]       approx_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [8:0]       exact_sum,
   output logic             err_flag,
   output logic [8:0]       err_dist,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

   state_t     r_state;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [8:0] r_approx;
   logic       r_carry;
   logic [1:0] r_idx;
   logic [3:0] r_low;
   logic [8:0] r_exact_sum;
   logic       r_err_flag;
   logic [8:0] r_err_dist;

   logic [3:0] w_a_lo;
   logic [3:0] w_b_lo;
   logic       w_ai;
   logic       w_bi;
   logic       w_sum_bit;
   logic       w_carry_bit;
   logic [4:0] w_high;
   logic [8:0] w_exact;
   logic [8:0] w_dist;
   logic       w_out_hs;

   // Low nibble is slices so the 2-bit index addresses it exactly
   assign w_a_lo      = r_a[3:0];
   assign w_b_lo      = r_b[3:0];
   assign w_ai        = w_a_lo[r_idx];
   assign w_bi        = w_b_lo[r_idx];
   assign w_sum_bit   = w_ai ^ w_bi ^ r_carry;
   assign w_carry_bit = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);

   // High nibble in one step, seeded with the carry out of the serial low part
   assign w_high  = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + {4'b0000, r_carry};
   assign w_exact = {w_high, r_low};
   assign w_dist  = (w_exact >= r_approx) ? (w_exact - r_approx) : (r_approx - w_exact);

   assign w_out_hs  = (r_state == S_DONE) && out_ready;
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign exact_sum = r_exact_sum;
   assign err_flag  = r_err_flag;
   assign err_dist  = r_err_dist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= 8'h00;
         r_b         <= 8'h00;
         r_approx    <= 9'h000;
         r_carry     <= 1'b0;
         r_idx       <= 2'd0;
         r_low       <= 4'h0;
         r_exact_sum <= 9'h000;
         r_err_flag  <= 1'b0;
         r_err_dist  <= 9'h000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_approx <= approx_sum;
                  r_carry  <= 1'b0;
                  r_idx    <= 2'd0;
                  r_state  <= S_LOW;
               end
            end
            S_LOW: begin
               r_low[r_idx] <= w_sum_bit;
               r_carry      <= w_carry_bit;
               r_idx        <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_state <= S_HIGH;
               end
            end
            S_HIGH: begin
               // Result outputs only change here, so they hold through DONE
               r_exact_sum <= w_exact;
               r_err_dist  <= w_dist;
               r_err_flag  <= (w_dist != 9'h000);
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ETA_CORR_STATS_EN
   logic [CNT_W-1:0] r_op_count;
   logic [CNT_W-1:0] r_err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count  <= '0;
         r_err_count <= '0;
      end else if (clr_stats) begin
         // Clear has priority over a coincident result handshake
         r_op_count  <= '0;
         r_err_count <= '0;
      end else if (w_out_hs) begin
         if (r_op_count != '1) begin
            r_op_count <= r_op_count + CNT_W'(1);
         end
         if (r_err_flag && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
      end
   end

   assign op_count  = r_op_count;
   assign err_count = r_err_count;
`else
   logic w_unused_stats;
   assign w_unused_stats = clr_stats ^ w_out_hs;
   assign op_count  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_eta_corrector_8bit.sv
// tb/tb_eta_corrector_8bit.sv - directed self-checking bench for eta_corrector_8bit

module tb_eta_corrector_8bit;

   localparam int TB_CNT_W = 2;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;
`ifdef ETA_CORR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          a;
   logic [7:0]          b;
   logic [8:0]          approx_sum;
   logic                out_valid;
   logic                out_ready;
   logic [8:0]          exact_sum;
   logic                err_flag;
   logic [8:0]          err_dist;
   logic                clr_stats;
   logic [TB_CNT_W-1:0] op_count;
   logic [TB_CNT_W-1:0] err_count;

   int n_checks;
   int n_pass;
   logic [TB_CNT_W-1:0] exp_op;
   logic [TB_CNT_W-1:0] exp_err;

   eta_corrector_8bit #(.CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .approx_sum (approx_sum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .exact_sum  (exact_sum),
      .err_flag   (err_flag),
      .err_dist   (err_dist),
      .clr_stats  (clr_stats),
      .op_count   (op_count),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helpers (no comparisons inside)
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [8:0] ts);
      a = ta; b = tb; approx_sum = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'hFF; b = 8'hFF; approx_sum = 9'h000;
   endtask

   task automatic wait_done(output int lat);
      int i;
      lat = 0;
      i = 0;
      while (lat == 0 && i < 20) begin
         i++;
         @(posedge clk); #1;
         if (out_valid) lat = i;
      end
   endtask

   task automatic handshake(input logic clr, input logic flag);
      out_ready = 1'b1; clr_stats = clr;
      @(posedge clk); #1;
      out_ready = 1'b0; clr_stats = 1'b0;
      if (STATS) begin
         if (clr) begin
            exp_op = '0; exp_err = '0;
         end else begin
            if (exp_op != CNT_MAX) exp_op = exp_op + 1'b1;
            if (flag && exp_err != CNT_MAX) exp_err = exp_err + 1'b1;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; #2;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_op = '0; exp_err = '0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if (exact_sum !== 9'h000) $display("FAIL rst_exact_sum got %h want 000", exact_sum); else n_pass++;
      n_checks++; if (err_flag !== 1'b0) $display("FAIL rst_err_flag got %b want 0", err_flag); else n_pass++;
      n_checks++; if (err_dist !== 9'h000) $display("FAIL rst_err_dist got %h want 000", err_dist); else n_pass++;
      n_checks++; if (op_count !== '0) $display("FAIL rst_op_count got %0d want 0", op_count); else n_pass++;
      n_checks++; if (err_count !== '0) $display("FAIL rst_err_count got %0d want 0", err_count); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_carry_chain();
      int lat;
      // Reset was released just before: this must be accepted on the first edge
      send(8'h0F, 8'h01, 9'h00E);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL first_accept in_ready got %b want 0", in_ready); else n_pass++;
      wait_done(lat);
      n_checks++; if (lat != 5) $display("FAIL latency got %0d want 5", lat); else n_pass++;
      n_checks++; if (exact_sum !== 9'h010) $display("FAIL cc_sum got %h want 010", exact_sum); else n_pass++;
      n_checks++; if (err_dist !== 9'd2) $display("FAIL cc_dist got %0d want 2", err_dist); else n_pass++;
      n_checks++; if (err_flag !== 1'b1) $display("FAIL cc_flag got %b want 1", err_flag); else n_pass++;
      handshake(1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL cc_idle out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
   endtask

   task automatic test_high_carry();
      int lat;
      apply_reset();
      send(8'h88, 8'h88, 9'h118);
      wait_done(lat);
      n_checks++; if (lat != 5) $display("FAIL hc_latency got %0d want 5", lat); else n_pass++;
      n_checks++; if (exact_sum !== 9'h110) $display("FAIL hc_sum got %h want 110", exact_sum); else n_pass++;
      n_checks++; if (err_dist !== 9'd8) $display("FAIL hc_dist got %0d want 8", err_dist); else n_pass++;
      n_checks++; if (err_flag !== 1'b1) $display("FAIL hc_flag got %b want 1", err_flag); else n_pass++;
      handshake(1'b0, 1'b1);
      n_checks++; if (op_count !== exp_op) $display("FAIL hc_op_count got %0d want %0d", op_count, exp_op); else n_pass++;
      n_checks++; if (err_count !== exp_err) $display("FAIL hc_err_count got %0d want %0d", err_count, exp_err); else n_pass++;
   endtask

   task automatic test_no_error();
      int lat;
      send(8'h30, 8'h40, 9'h070);
      wait_done(lat);
      n_checks++; if (exact_sum !== 9'h070) $display("FAIL ne_sum got %h want 070", exact_sum); else n_pass++;
      n_checks++; if (err_dist !== 9'd0) $display("FAIL ne_dist got %0d want 0", err_dist); else n_pass++;
      n_checks++; if (err_flag !== 1'b0) $display("FAIL ne_flag got %b want 0", err_flag); else n_pass++;
      handshake(1'b0, 1'b0);
      n_checks++; if (op_count !== exp_op) $display("FAIL ne_op_count got %0d want %0d", op_count, exp_op); else n_pass++;
      n_checks++; if (err_count !== exp_err) $display("FAIL ne_err_count got %0d want %0d", err_count, exp_err); else n_pass++;
   endtask

   task automatic test_back_pressure();
      int lat;
      a = 8'h12; b = 8'h34; approx_sum = 9'h046; in_valid = 1'b1;
      @(posedge clk); #1;
      // Keep in_valid high with different operands: they must be ignored
      a = 8'hFF; b = 8'hFF; approx_sum = 9'h000;
      wait_done(lat);
      n_checks++; if (lat != 5) $display("FAIL bp_latency got %0d want 5", lat); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, out_valid); else n_pass++;
         n_checks++; if (exact_sum !== 9'h046 || err_dist !== 9'd0 || err_flag !== 1'b0)
            $display("FAIL bp_hold_data cycle %0d got sum=%h dist=%0d flag=%b want 046/0/0", i, exact_sum, err_dist, err_flag); else n_pass++;
         n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); else n_pass++;
      end
      handshake(1'b0, 1'b0);
      // in_valid still high across the output handshake: nothing accepted in that cycle
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
      in_valid = 1'b0;
      n_checks++; if (op_count !== exp_op) $display("FAIL bp_op_count got %0d want %0d", op_count, exp_op); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      send(8'h55, 8'h66, 9'h0BB);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      exp_op = '0; exp_err = '0;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rm_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
      n_checks++; if (exact_sum !== 9'h000 || err_dist !== 9'h000 || err_flag !== 1'b0)
         $display("FAIL rm_outputs got sum=%h dist=%h flag=%b want 000/000/0", exact_sum, err_dist, err_flag); else n_pass++;
      n_checks++; if (op_count !== '0 || err_count !== '0) $display("FAIL rm_counts got %0d/%0d want 0/0", op_count, err_count); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL rm_no_result got out_valid seen=%b want 0", seen); else n_pass++;
      send(8'h0F, 8'h01, 9'h00F);
      wait_done(lat);
      n_checks++; if (lat != 5) $display("FAIL rm_latency got %0d want 5", lat); else n_pass++;
      n_checks++; if (exact_sum !== 9'h010 || err_dist !== 9'd1 || err_flag !== 1'b1)
         $display("FAIL rm_next got sum=%h dist=%0d flag=%b want 010/1/1", exact_sum, err_dist, err_flag); else n_pass++;
      handshake(1'b0, 1'b1);
   endtask

   task automatic test_extremes_saturation();
      int lat;
      send(8'hFF, 8'hFF, 9'h0FE);
      wait_done(lat);
      n_checks++; if (exact_sum !== 9'h1FE || err_dist !== 9'h100 || err_flag !== 1'b1)
         $display("FAIL ex_max got sum=%h dist=%h flag=%b want 1FE/100/1", exact_sum, err_dist, err_flag); else n_pass++;
      handshake(1'b0, 1'b1);
      send(8'h01, 8'h02, 9'h1FF);
      wait_done(lat);
      n_checks++; if (exact_sum !== 9'h003 || err_dist !== 9'h1FC || err_flag !== 1'b1)
         $display("FAIL ex_over got sum=%h dist=%h flag=%b want 003/1FC/1", exact_sum, err_dist, err_flag); else n_pass++;
      handshake(1'b0, 1'b1);
      send(8'h80, 8'h80, 9'h000);
      wait_done(lat);
      n_checks++; if (exact_sum !== 9'h100 || err_dist !== 9'h100) $display("FAIL ex_msb got sum=%h dist=%h want 100/100", exact_sum, err_dist); else n_pass++;
      handshake(1'b0, 1'b1);
      n_checks++; if (op_count !== exp_op) $display("FAIL sat_op_count got %0d want %0d", op_count, exp_op); else n_pass++;
      n_checks++; if (err_count !== exp_err) $display("FAIL sat_err_count got %0d want %0d", err_count, exp_err); else n_pass++;
   endtask

   task automatic test_clear();
      int lat;
      send(8'h0F, 8'h01, 9'h00E);
      wait_done(lat);
      handshake(1'b1, 1'b1);
      n_checks++; if (op_count !== '0 || err_count !== '0) $display("FAIL clr_counts got %0d/%0d want 0/0", op_count, err_count); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL clr_idle in_ready got %b want 1", in_ready); else n_pass++;
      send(8'h01, 8'h01, 9'h003);
      wait_done(lat);
      handshake(1'b0, 1'b1);
      n_checks++; if (op_count !== exp_op || err_count !== exp_err)
         $display("FAIL clr_after got %0d/%0d want %0d/%0d", op_count, err_count, exp_op, exp_err); else n_pass++;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      exp_op = '0; exp_err = '0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
      a = 8'h0F; b = 8'h01; approx_sum = 9'h00E;
      test_reset();
      test_carry_chain();
      test_high_carry();
      test_no_error();
      test_back_pressure();
      test_reset_mid();
      test_extremes_saturation();
      test_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eta_corrector_8bit.md
ETA_CORRECTOR_8BIT -- requirements
Module: eta_corrector_8bit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of statistics counters.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand/approx-sum triple valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a triple.
REQ-006 SHALL have ports a, b  input  8 each  original adder operands.
REQ-007 SHALL have port approx_sum  input  9  result produced by the 8-bit error-tolerant adder.
REQ-008 SHALL have port out_valid  output  1  corrected result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port exact_sum  output  9  corrected sum a+b.
REQ-011 SHALL have port err_flag  output  1  approx_sum differed from exact_sum.
REQ-012 SHALL have port err_dist  output  9  |exact_sum - approx_sum|.
REQ-013 SHALL have port clr_stats  input  1  synchronous clear of counters.
REQ-014 SHALL have ports op_count, err_count  output  CNT_W each  completed results / erroneous results.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; input handshake = in_valid & in_ready.
REQ-017 On input handshake SHALL register a, b, approx_sum, clear carry register, bit index := 0, go LOW.
REQ-018 In LOW SHALL compute one exact low-nibble bit per cycle (sum = a^b^c, carry = majority) for index 0..3; after index 3 go HIGH.
REQ-019 In HIGH SHALL add high nibbles plus LOW carry in one cycle, forming exact_sum[8:4], then compute err_dist and err_flag, go DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE; first cycle with out_valid=1 is 5 rising edges after the input handshake edge.
REQ-021 exact_sum, err_flag, err_dist SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 On output handshake (out_valid & out_ready) SHALL return to IDLE; no new input accepted in that same cycle.
REQ-023 err_dist SHALL be 9-bit unsigned absolute difference; err_flag = (err_dist != 0).
REQ-024 On output handshake op_count SHALL increment by 1, and err_count by 1 if err_flag; both saturate at all-ones.
REQ-025 clr_stats=1 SHALL zero both counters next edge; clear wins over simultaneous increment.
REQ-026 in_valid while busy SHALL be ignored; operand inputs sampled only at handshake.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, exact_sum=0, err_flag=0, err_dist=0, counters=0, carry and index=0.
REQ-028 Reset asserted mid-transaction SHALL discard that transaction; no output handshake produced for it.
REQ-029 After rst_n deassertion, first input handshake SHALL be possible on the first rising edge.

Configuration
REQ-030 Macro ETA_CORR_STATS_EN defined: counters and clr_stats behave per REQ-024/025.
REQ-031 Macro ETA_CORR_STATS_EN undefined: no counter registers; op_count, err_count tied to 0; clr_stats ignored; all other behaviour identical.

Verification
REQ-032 a=0x0F, b=0x01, approx_sum=0x00E -> exact_sum=0x010, err_dist=2, err_flag=1, out_valid 5 edges after accept.
REQ-033 a=0x88, b=0x88, approx_sum=0x118 -> exact_sum=0x110, err_dist=8, err_flag=1; op_count=1, err_count=1.
REQ-034 a=0x30, b=0x40, approx_sum=0x070 -> exact_sum=0x070, err_dist=0, err_flag=0; err_count unchanged.
REQ-035 out_ready held 0 for 3 cycles in DONE, in_valid=1 throughout -> outputs stable, in_ready=0, single result then IDLE.
REQ-036 rst_n pulsed low during LOW index 2 -> all outputs at reset values immediately, no out_valid; next transaction correct.
REQ-037 clr_stats=1 coincident with erroneous output handshake -> op_count=0, err_count=0 next cycle; with macro undefined counters read 0 always.
